hazard_ctrl_mc: RTL

//  Parametrised hazard/forwarding controller for the 5-stage MIPS pipe with a multi-cycle MULT/DIV unit.

---
 rtl/hazard_pkg.sv | 32 +++
 rtl/hazard_md_tracker.sv | 52 +++++
 rtl/hazard_ctrl_mc.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the hazard/forwarding controller.
// Forward-select codes, MD tracker state encoding and the register-hit test.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_MD_BUSY = 1'b1;

    // Register addresses are zero-extended to this width before comparison.
    localparam int unsigned REG_AW_MAX = 8;

    // Winning stall cause, highest priority first.
    typedef enum logic [2:0] {
        CauseNone,
        CauseMem,
        CauseMdStruct,
        CauseMdRead,
        CauseLoad,
        CauseBranch
    } stallCause_e;

    // True when a non-zero source matches a destination that is being written.
    function automatic logic src_hit(input logic [REG_AW_MAX-1:0] src,
                                     input logic [REG_AW_MAX-1:0] dst,
                                     input logic                  we);
        return we && (src != '0) && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_md_tracker.sv
// HI/LO busy tracker for the multi-cycle MULT/DIV unit.
// Two-state FSM with a 3-bit down-counter; last flags the final busy cycle.
module hazard_md_tracker
    import hazard_pkg::*;
#(
    parameter int unsigned MD_LAT = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic i_memWait,
    output logic o_busy,
    output logic o_last
);

    localparam logic [2:0] CNT_LOAD = 3'(MD_LAT - 1);

    logic [0:0] stateQ, stateD;
    logic [2:0] cntQ, cntD;
    logic       accept;

    // A start stalled by memory wait stays in E and is not taken.
    assign accept = i_start && !i_memWait && ((stateQ == ST_IDLE) || (cntQ == 3'd1));

    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        if (accept) begin
            stateD = ST_MD_BUSY;
            cntD   = CNT_LOAD;
        end else if (stateQ == ST_MD_BUSY) begin
            cntD = cntQ - 3'd1;
            if (cntQ == 3'd1) begin
                stateD = ST_IDLE;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stateQ <= ST_IDLE;
            cntQ   <= 3'd0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
        end
    end

    assign o_busy = (stateQ == ST_MD_BUSY);
    assign o_last = o_busy && (cntQ == 3'd1);

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Hazard/forwarding controller for the 5-stage MIPS pipe with multi-cycle MULT/DIV and slow dmem.
// Define HAZARD_PERF_CNT_EN to add saturating per-cause stall counters.
module hazard_ctrl_mc
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned MD_LAT = 4
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W  = 16
`endif
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_reg_writeE,
    input  logic              i_reg_writeM,
    input  logic              i_reg_writeW,
    input  logic              i_mem_to_regE,
    input  logic              i_mem_to_regM,
    input  logic [REG_AW-1:0] i_write_regE,
    input  logic [REG_AW-1:0] i_write_regM,
    input  logic [REG_AW-1:0] i_write_regW,
    input  logic [REG_AW-1:0] i_rsD,
    input  logic [REG_AW-1:0] i_rtD,
    input  logic [REG_AW-1:0] i_rsE,
    input  logic [REG_AW-1:0] i_rtE,
    input  logic              i_branchD,
    input  logic              i_md_startE,
    input  logic              i_md_readD,
    input  logic              i_mem_accessM,
    input  logic              i_dmem_ready,
    output logic [1:0]        o_forward_AE,
    output logic [1:0]        o_forward_BE,
    output logic              o_forward_AD,
    output logic              o_forward_BD,
    output logic              o_stallF,
    output logic              o_stallD,
    output logic              o_stallE,
    output logic              o_stallM,
    output logic              o_flushE,
    output logic              o_flushM,
    output logic              o_flushW,
    output logic              o_md_busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  o_lw_cnt,
    output logic [CNT_W-1:0]  o_br_cnt,
    output logic [CNT_W-1:0]  o_md_cnt,
    output logic [CNT_W-1:0]  o_mem_cnt
`endif
);

    function automatic logic [REG_AW_MAX-1:0] wid(input logic [REG_AW-1:0] r);
        return REG_AW_MAX'(r);
    endfunction

    function automatic logic [1:0] fwdSel(input logic [REG_AW-1:0] src,
                                          input logic [REG_AW-1:0] wrM,
                                          input logic              weM,
                                          input logic [REG_AW-1:0] wrW,
                                          input logic              weW);
        if (src_hit(wid(src), wid(wrM), weM)) begin
            return FWD_MEM;
        end else if (src_hit(wid(src), wid(wrW), weW)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

    logic        memWait, lwStall, brStall, mdStruct, mdRead;
    logic        mdBusy, mdLast;
    stallCause_e cause;

    hazard_md_tracker #(
        .MD_LAT (MD_LAT)
    ) u_mdTracker (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_start   (i_md_startE),
        .i_memWait (memWait),
        .o_busy    (mdBusy),
        .o_last    (mdLast)
    );

    assign o_forward_AE = fwdSel(i_rsE, i_write_regM, i_reg_writeM, i_write_regW, i_reg_writeW);
    assign o_forward_BE = fwdSel(i_rtE, i_write_regM, i_reg_writeM, i_write_regW, i_reg_writeW);
    assign o_forward_AD = src_hit(wid(i_rsD), wid(i_write_regM), i_reg_writeM);
    assign o_forward_BD = src_hit(wid(i_rtD), wid(i_write_regM), i_reg_writeM);

    assign memWait = i_mem_accessM & ~i_dmem_ready;

    assign lwStall = src_hit(wid(i_rsD), wid(i_write_regE), i_mem_to_regE)
                   | src_hit(wid(i_rtD), wid(i_write_regE), i_mem_to_regE);

    assign brStall = i_branchD
                   & (src_hit(wid(i_rsD), wid(i_write_regE), i_reg_writeE)
                    | src_hit(wid(i_rtD), wid(i_write_regE), i_reg_writeE)
                    | src_hit(wid(i_rsD), wid(i_write_regM), i_mem_to_regM)
                    | src_hit(wid(i_rtD), wid(i_write_regM), i_mem_to_regM));

    // A start on the last busy cycle is accepted, so it is not a structural hazard.
    assign mdStruct = mdBusy & i_md_startE & ~mdLast;
    assign mdRead   = mdBusy & i_md_readD;

    always_comb begin
        cause = CauseNone;
        if (i_rst) begin
            cause = CauseNone;
        end else if (memWait) begin
            cause = CauseMem;
        end else if (mdStruct) begin
            cause = CauseMdStruct;
        end else if (mdRead) begin
            cause = CauseMdRead;
        end else if (lwStall) begin
            cause = CauseLoad;
        end else if (brStall) begin
            cause = CauseBranch;
        end
    end

    always_comb begin
        o_stallF = 1'b0;
        o_stallD = 1'b0;
        o_stallE = 1'b0;
        o_stallM = 1'b0;
        o_flushE = 1'b0;
        o_flushM = 1'b0;
        o_flushW = 1'b0;
        case (cause)
            CauseMem: begin
                o_stallF = 1'b1;
                o_stallD = 1'b1;
                o_stallE = 1'b1;
                o_stallM = 1'b1;
                o_flushW = 1'b1;
            end
            CauseMdStruct: begin
                o_stallF = 1'b1;
                o_stallD = 1'b1;
                o_stallE = 1'b1;
                o_flushM = 1'b1;
            end
            CauseMdRead, CauseLoad, CauseBranch: begin
                o_stallF = 1'b1;
                o_stallD = 1'b1;
                o_flushE = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_md_busy = mdBusy;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] lwCntQ, brCntQ, mdCntQ, memCntQ;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lwCntQ  <= '0;
            brCntQ  <= '0;
            mdCntQ  <= '0;
            memCntQ <= '0;
        end else begin
            lwCntQ  <= satInc(lwCntQ, cause == CauseLoad);
            brCntQ  <= satInc(brCntQ, cause == CauseBranch);
            mdCntQ  <= satInc(mdCntQ, (cause == CauseMdStruct) || (cause == CauseMdRead));
            memCntQ <= satInc(memCntQ, cause == CauseMem);
        end
    end

    assign o_lw_cnt  = lwCntQ;
    assign o_br_cnt  = brCntQ;
    assign o_md_cnt  = mdCntQ;
    assign o_mem_cnt = memCntQ;
`endif

endmodule
